// File: rtl/hamming_pkg.sv
// Shared definitions for the SECDED decode engine: error flags, FSM states
// and the default memory layout of the encoded/decoded buffers.
package hamming_pkg;

  localparam logic [1:0] FLAG_OK  = 2'b00;
  localparam logic [1:0] FLAG_SEC = 2'b01;
  localparam logic [1:0] FLAG_DED = 2'b10;

  localparam int DEF_NUM_WORDS = 15;
  localparam int DEF_SRC_BASE  = 30;
  localparam int DEF_DST_BASE  = 0;
  localparam int DEF_ADDR_W    = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    FIN   = 3'd5
  } state_t;

endpackage

// File: rtl/secded_dec16.sv
// Combinational SECDED decoder for one 16-bit extended-Hamming codeword
// (bit k = Hamming position k, bit 0 = overall parity).
module secded_dec16 (
  input  logic [15:0] word,
  output logic [10:0] data,
  output logic [1:0]  flag,
  output logic [3:0]  syndrome
);
  import hamming_pkg::*;

  // Hamming positions of d1..d11; everything else is a parity bit.
  localparam logic [3:0] DPOS [11] = '{
    4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
  };

  logic parity;

  always_comb begin
    syndrome = 4'd0;
    for (int k = 1; k < 16; k++) begin
      if (word[k]) syndrome = syndrome ^ 4'(k);
    end
    parity = ^word;
  end

  always_comb begin
    flag = FLAG_OK;
    if (parity) flag = FLAG_SEC;
    else if (syndrome != 4'd0) flag = FLAG_DED;
    // A single error only touches data when the syndrome points at a data slot.
    for (int i = 0; i < 11; i++) begin
      data[i] = word[DPOS[i]] ^ (parity && (syndrome == DPOS[i]));
    end
  end

endmodule

// File: rtl/hamming_dec_engine.sv
// Memory-mapped SECDED decode engine: reads NUM_WORDS codewords byte by byte,
// corrects/flags them and writes {flag, data} words back to the destination area.
module hamming_dec_engine import hamming_pkg::*; #(
  parameter int NUM_WORDS = DEF_NUM_WORDS,
  parameter int SRC_BASE  = DEF_SRC_BASE,
  parameter int DST_BASE  = DEF_DST_BASE,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wr_data,
  output logic              done,
  output logic [3:0]        err1_cnt,
  output logic [3:0]        err2_cnt
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [15:0]       word;
  logic [10:0]       dec_data;
  logic [1:0]        dec_flag;
  logic [3:0]        dec_syndrome_unused;
  logic [7:0]        lsb_byte, msb_byte;
  logic [ADDR_W-1:0] word_off, src_addr, dst_addr;

  secded_dec16 u_dec (
    .word     (word),
    .data     (dec_data),
    .flag     (dec_flag),
    .syndrome (dec_syndrome_unused)
  );

  assign lsb_byte = dec_data[7:0];
  assign msb_byte = {dec_flag, 3'b000, dec_data[10:8]};

  assign word_off = ADDR_W'(idx) << 1;
  assign src_addr = ADDR_W'(SRC_BASE) + word_off;
  assign dst_addr = ADDR_W'(DST_BASE) + word_off;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      idx      <= '0;
      done     <= 1'b0;
      err1_cnt <= 4'd0;
      err2_cnt <= 4'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            idx      <= '0;
            done     <= 1'b0;
            err1_cnt <= 4'd0;
            err2_cnt <= 4'd0;
          end
        end
        WR_LO: begin
          if (dec_flag == FLAG_SEC) err1_cnt <= sat_inc(err1_cnt);
          if (dec_flag == FLAG_DED) err2_cnt <= sat_inc(err2_cnt);
        end
        WR_HI: begin
          if (idx != LAST_IDX) idx <= idx + IDX_W'(1);
        end
        FIN:     done <= 1'b1;
        default: ;
      endcase
    end
  end

  // Codeword byte latches; only meaningful between RD_HI and WR_HI.
  always_ff @(posedge clk) begin
    if (state == RD_LO) word[7:0]  <= mem_rd_data;
    if (state == RD_HI) word[15:8] <= mem_rd_data;
  end

  always_comb begin
    state_nxt   = state;
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = 8'h00;
    case (state)
      IDLE: begin
        if (start) state_nxt = RD_LO;
      end
      RD_LO: begin
        mem_addr  = src_addr;
        state_nxt = RD_HI;
      end
      RD_HI: begin
        mem_addr  = src_addr + ADDR_W'(1);
        state_nxt = WR_LO;
      end
      WR_LO: begin
        mem_addr    = dst_addr;
        mem_wr_en   = 1'b1;
        mem_wr_data = lsb_byte;
        state_nxt   = WR_HI;
      end
      WR_HI: begin
        mem_addr    = dst_addr + ADDR_W'(1);
        mem_wr_en   = 1'b1;
        mem_wr_data = msb_byte;
        state_nxt   = (idx == LAST_IDX) ? FIN : RD_LO;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hamming_dec_engine.sv
// Scoreboard bench for hamming_dec_engine: a byte memory model, a textbook
// Hamming encoder with bit-flip injection, and a write monitor fed by a queue.
module tb_hamming_dec_engine;

  localparam int NW  = 15;
  localparam int SRC = 30;
  localparam int DST = 0;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;
  logic       done;
  logic [3:0] err1_cnt;
  logic [3:0] err2_cnt;

  always #5 clk = ~clk;

  hamming_dec_engine dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .done        (done),
    .err1_cnt    (err1_cnt),
    .err2_cnt    (err2_cnt)
  );

  logic [7:0] mem [0:255];
  assign mem_rd_data = mem[mem_addr];
  always @(posedge clk) if (mem_wr_en === 1'b1) mem[mem_addr] = mem_wr_data;

  typedef struct { logic [7:0] addr; logic [7:0] data; } wr_t;
  wr_t sb[$];

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_dst  [0:2*NW-1];
  logic [7:0] src_copy [0:2*NW-1];
  int exp_e1, exp_e2;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (mem_wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write",
                 mem_addr, mem_wr_data);
      end else begin
        e = sb.pop_front();
        check("wr_addr", int'(mem_addr), int'(e.addr));
        check("wr_data", int'(mem_wr_data), int'(e.data));
      end
    end
  end

  function automatic bit is_pow2(input int k);
    return (k & (k - 1)) == 0;
  endfunction

  // Data bits fill the non-power-of-two positions in ascending order.
  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] w = '0;
    int j = 0;
    for (int k = 1; k < 16; k++) if (!is_pow2(k)) begin w[k] = d[j]; j++; end
    for (int p = 1; p < 16; p = p * 2) begin
      logic b = 1'b0;
      for (int k = 1; k < 16; k++) if ((k & p) != 0 && k != p) b ^= w[k];
      w[p] = b;
    end
    w[0] = ^w[15:1];
    return w;
  endfunction

  function automatic logic [10:0] extract(input logic [15:0] w);
    logic [10:0] d = '0;
    int j = 0;
    for (int k = 1; k < 16; k++) if (!is_pow2(k)) begin d[j] = w[k]; j++; end
    return d;
  endfunction

  task automatic set_word(input int j, input logic [15:0] cw, input logic [7:0] lsb,
                          input logic [7:0] msb);
    mem[SRC + 2*j]     = cw[7:0];
    mem[SRC + 2*j + 1] = cw[15:8];
    exp_dst[2*j]       = lsb;
    exp_dst[2*j + 1]   = msb;
  endtask

  task automatic rand_word(input int j);
    logic [10:0] d, dout;
    logic [15:0] cw;
    logic [1:0]  f;
    int n, a, b;
    d  = 11'($urandom);
    cw = encode(d);
    n  = $urandom_range(0, 2);
    a  = $urandom_range(0, 15);
    b  = a;
    while (b == a) b = $urandom_range(0, 15);
    if (n >= 1) cw[a] = ~cw[a];
    if (n == 2) cw[b] = ~cw[b];
    f    = (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b10;
    dout = (n == 2) ? extract(cw) : d;
    if (n == 1) exp_e1++;
    if (n == 2) exp_e2++;
    set_word(j, cw, dout[7:0], {f, 3'b000, dout[10:8]});
  endtask

  task automatic prep(input bit directed, input int words_expected);
    exp_e1 = 0;
    exp_e2 = 0;
    for (int j = 0; j < NW; j++) rand_word(j);
    if (directed) begin
      exp_e1 = 0;
      exp_e2 = 0;
      for (int j = 4; j < NW; j++) rand_word(j);
      set_word(0, 16'hFFFF, 8'hFF, 8'h07);
      set_word(1, 16'h0020, 8'h00, 8'h40);
      set_word(2, 16'h0001, 8'h00, 8'h40);
      set_word(3, 16'hFDF7, 8'hEE, 8'h87);
      exp_e1 += 2;
      exp_e2 += 1;
    end
    for (int j = 0; j < 2*NW; j++) begin
      mem[DST + j] = 8'($urandom);
      src_copy[j]  = mem[SRC + j];
    end
    for (int j = 0; j < words_expected; j++) begin
      sb.push_back('{addr: 8'(DST + 2*j),     data: exp_dst[2*j]});
      sb.push_back('{addr: 8'(DST + 2*j + 1), data: exp_dst[2*j + 1]});
    end
  endtask

  // Cycle c counts rising edges after the one that samples start.
  task automatic do_run(input int abort_at, input int extra_start_at, output int done_cyc);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_cyc = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 && done_cyc < 0) done_cyc = c;
      if (c == extra_start_at) start = 1'b1;
      if (c == extra_start_at + 1) start = 1'b0;
      if (abort_at > 0) begin
        if (c == abort_at - 1) reset = 1'b0;
        if (c == abort_at) reset = 1'b1;
        if (c == abort_at + 10) break;
      end else if (done_cyc > 0) begin
        break;
      end
    end
  endtask

  task automatic check_full_run(input string tag, input int done_cyc);
    check({tag, "_done_cycle"}, done_cyc, 61);
    check({tag, "_err1_cnt"}, int'(err1_cnt), exp_e1);
    check({tag, "_err2_cnt"}, int'(err2_cnt), exp_e2);
    check({tag, "_sb_empty"}, sb.size(), 0);
    for (int j = 0; j < 2*NW; j++) begin
      check($sformatf("%s_dst[%0d]", tag, j), int'(mem[DST + j]), int'(exp_dst[j]));
      check($sformatf("%s_src[%0d]", tag, j), int'(mem[SRC + j]), int'(src_copy[j]));
    end
    repeat (3) @(posedge clk);
    #1 check({tag, "_done_held"}, int'(done), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dc;
    reset = 1'b0;
    start = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", int'(done), 0);
    check("rst_wr_en", int'(mem_wr_en), 0);
    check("rst_addr", int'(mem_addr), 0);
    check("rst_wr_data", int'(mem_wr_data), 0);
    check("rst_err1", int'(err1_cnt), 0);
    check("rst_err2", int'(err2_cnt), 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    prep(1'b1, NW);
    do_run(0, 0, dc);
    check_full_run("directed", dc);

    prep(1'b0, NW);
    do_run(0, 10, dc);
    check_full_run("restart_ignored", dc);

    prep(1'b0, 5);
    do_run(20, 0, dc);
    check("abort_done", dc, -1);
    check("abort_sb_empty", sb.size(), 0);
    check("abort_err1", int'(err1_cnt), 0);
    check("abort_err2", int'(err2_cnt), 0);
    for (int j = 10; j < 2*NW; j++)
      if (mem[DST + j] === exp_dst[j] && mem[DST + j] !== 8'hxx) begin end

    prep(1'b0, NW);
    do_run(0, 0, dc);
    check_full_run("after_abort", dc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
